// File: rtl/dcache_mem_arbiter_if.sv
// rtl/dcache_mem_arbiter_if.sv - read/write request bus shared by dcache ports and memory channels
interface dcache_mem_arbiter_if #(
  parameter int N         = 8,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic [N-1:0]                read_valid;
  logic [N-1:0][ADDR_BITS-1:0] read_address;
  logic [N-1:0]                read_ready;
  logic [N-1:0][DATA_BITS-1:0] read_data;
  logic [N-1:0]                write_valid;
  logic [N-1:0][ADDR_BITS-1:0] write_address;
  logic [N-1:0][DATA_BITS-1:0] write_data;
  logic [N-1:0]                write_ready;

  // master issues requests and consumes acks; slave does the opposite
  modport master (
    output read_valid, read_address, write_valid, write_address, write_data,
    input  read_ready, read_data, write_ready
  );
  modport slave (
    input  read_valid, read_address, write_valid, write_address, write_data,
    output read_ready, read_data, write_ready
  );
endinterface

// File: rtl/dcache_mem_arbiter.sv
// rtl/dcache_mem_arbiter.sv - round-robin sharing of memory channels among dcache request ports
module dcache_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  dcache_mem_arbiter_if.slave  cache_if,
  dcache_mem_arbiter_if.master mem_if
);

  localparam int PW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [PW:0] NC_W = (PW+1)'(NUM_CONSUMERS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;
  localparam logic [1:0] ST_RELAY   = 2'd3;

  // per-channel transaction state
  logic [NUM_CHANNELS-1:0][1:0]    state_q, state_d;
  logic [NUM_CHANNELS-1:0][PW-1:0] port_q, port_d;
  logic [NUM_CHANNELS-1:0]         rd_op_q, rd_op_d;

  // per-port ownership and fairness pointer
  logic [NUM_CONSUMERS-1:0] busy_q, busy_d;
  logic [PW-1:0]            rr_q, rr_d;

  // registered memory-side outputs
  logic [NUM_CHANNELS-1:0]                mrv_q, mrv_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mra_q, mra_d;
  logic [NUM_CHANNELS-1:0]                mwv_q, mwv_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mwa_q, mwa_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mwd_q, mwd_d;

  // registered cache-side outputs
  logic [NUM_CONSUMERS-1:0]                crr_q, crr_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] crd_q, crd_d;
  logic [NUM_CONSUMERS-1:0]                cwr_q, cwr_d;

  // arbitration scratch
  logic [NUM_CHANNELS-1:0] taken;
  logic                    found;
  logic [PW:0]             scan;
  logic [PW:0]             nxt;
  logic [PW-1:0]           p;

  // channel FSMs advance, then free idle channels are handed to eligible ports in rr order
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    rd_op_d = rd_op_q;
    busy_d  = busy_q;
    rr_d    = rr_q;
    mrv_d   = mrv_q;
    mra_d   = mra_q;
    mwv_d   = mwv_q;
    mwa_d   = mwa_q;
    mwd_d   = mwd_q;
    crr_d   = crr_q;
    crd_d   = crd_q;
    cwr_d   = cwr_q;
    taken   = '0;
    found   = 1'b0;
    scan    = '0;
    nxt     = '0;
    p       = '0;

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (state_q[c])
        ST_RD_WAIT: begin
          if (mem_if.read_ready[c]) begin
            mrv_d[c]            = 1'b0;
            mra_d[c]            = '0;
            crr_d[port_q[c]]    = 1'b1;
            crd_d[port_q[c]]    = mem_if.read_data[c];
            state_d[c]          = ST_RELAY;
          end
        end
        ST_WR_WAIT: begin
          if (mem_if.write_ready[c]) begin
            mwv_d[c]         = 1'b0;
            mwa_d[c]         = '0;
            mwd_d[c]         = '0;
            cwr_d[port_q[c]] = 1'b1;
            state_d[c]       = ST_RELAY;
          end
        end
        ST_RELAY: begin
          // hold the ack until the requester withdraws the matching valid
          if (rd_op_q[c] ? !cache_if.read_valid[port_q[c]] : !cache_if.write_valid[port_q[c]]) begin
            if (rd_op_q[c]) begin
              crr_d[port_q[c]] = 1'b0;
              crd_d[port_q[c]] = '0;
            end else begin
              cwr_d[port_q[c]] = 1'b0;
            end
            busy_d[port_q[c]] = 1'b0;
            state_d[c]        = ST_IDLE;
          end
        end
        default: ;
      endcase
    end

    // busy_q is still set for a port leaving RELAY this cycle, so it cannot be regranted yet
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      scan = {1'b0, rr_q} + (PW+1)'(i);
      if (scan >= NC_W) scan = scan - NC_W;
      p = scan[PW-1:0];
      if ((cache_if.read_valid[p] || cache_if.write_valid[p]) && !busy_q[p]) begin
        found = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          if (!found && !taken[c] && state_q[c] == ST_IDLE) begin
            found      = 1'b1;
            taken[c]   = 1'b1;
            port_d[c]  = p;
            rd_op_d[c] = cache_if.read_valid[p];
            busy_d[p]  = 1'b1;
            if (cache_if.read_valid[p]) begin
              state_d[c] = ST_RD_WAIT;
              mrv_d[c]   = 1'b1;
              mra_d[c]   = cache_if.read_address[p];
            end else begin
              state_d[c] = ST_WR_WAIT;
              mwv_d[c]   = 1'b1;
              mwa_d[c]   = cache_if.write_address[p];
              mwd_d[c]   = cache_if.write_data[p];
            end
          end
        end
        if (found) begin
          nxt = scan + (PW+1)'(1);
          if (nxt == NC_W) nxt = '0;
          rr_d = nxt[PW-1:0];
        end
      end
    end
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= '0;
      port_q  <= '0;
      rd_op_q <= '0;
      busy_q  <= '0;
      rr_q    <= '0;
      mrv_q   <= '0;
      mra_q   <= '0;
      mwv_q   <= '0;
      mwa_q   <= '0;
      mwd_q   <= '0;
      crr_q   <= '0;
      crd_q   <= '0;
      cwr_q   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      rd_op_q <= rd_op_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      mrv_q   <= mrv_d;
      mra_q   <= mra_d;
      mwv_q   <= mwv_d;
      mwa_q   <= mwa_d;
      mwd_q   <= mwd_d;
      crr_q   <= crr_d;
      crd_q   <= crd_d;
      cwr_q   <= cwr_d;
    end
  end

  assign mem_if.read_valid     = mrv_q;
  assign mem_if.read_address   = mra_q;
  assign mem_if.write_valid    = mwv_q;
  assign mem_if.write_address  = mwa_q;
  assign mem_if.write_data     = mwd_q;
  assign cache_if.read_ready   = crr_q;
  assign cache_if.read_data    = crd_q;
  assign cache_if.write_ready  = cwr_q;

endmodule
